i2si_param_fifo: RTL and testbench
==================================

# i2si_param_fifo

Parametrised successor to the I2S-input byte FIFO, sitting between the I2S deserialiser (write side) and the downstream sample consumer (read side). Generalises data width and depth, switches to first-word-fall-through output, and adds synchronous flush, programmable almost-full/almost-empty flags, and sticky overflow/underflow error flags. Both sides use the rts/rtr handshake already used in the I2S input path.

## Interface
- DATA_W, 8, data bits per entry
- ADDR_W, 3, pointer width; DEPTH = 2**ADDR_W entries
- AFULL_LVL, DEPTH-2, almost-full threshold (count >= level)
- AEMPTY_LVL, 1, almost-empty threshold (count <= level)

- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous clear of contents and error flags
- i2si_fifo_inp_data  in  DATA_W  write data
- i2si_fifo_inp_rts  in  1  writer has data
- i2si_fifo_inp_rtr  out  1  FIFO can accept (not full)
- i2si_fifo_out_data  out  DATA_W  head-of-queue data (FWFT)
- i2si_fifo_out_rts  out  1  FIFO has data (not empty)
- i2si_fifo_out_rtr  in  1  reader consumes head
- fifo_counter  out  ADDR_W+1  entries held, 0..DEPTH
- almost_full  out  1  fifo_counter >= AFULL_LVL
- almost_empty  out  1  fifo_counter <= AEMPTY_LVL
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty

## Operation
- wr_fire = inp_rts & inp_rtr & ~flush; rd_fire = out_rts & out_rtr & ~flush.
- inp_rtr = (fifo_counter != DEPTH); out_rts = (fifo_counter != 0); both decoded from registered count only, never from same-cycle rd/wr (no full pass-through, no empty bypass).
- wr_fire: mem[wr_ptr] <= inp_data, wr_ptr++. rd_fire: rd_ptr++. Pointers wrap modulo DEPTH naturally (ADDR_W bits).
- Count: +1 on wr_fire only, -1 on rd_fire only, unchanged on both or neither.
- out_data = mem[rd_ptr] when out_rts = 1, else all zeros (deterministic when empty).
- overflow set when inp_rts & ~inp_rtr & ~flush; underflow set when out_rtr & ~out_rts & ~flush; held until flush or reset.
- flush: pointers, count, overflow, underflow to 0 next edge; overrides any same-cycle wr/rd (both dropped, no error flagged).
- Memory array not reset; contents irrelevant after reset/flush as count = 0.
- Parameter legality: 1 <= ADDR_W, AEMPTY_LVL < AFULL_LVL <= DEPTH; violations are elaboration errors.

## Timing
- Reset (rst_n low, async): counter 0, pointers 0, overflow/underflow 0; hence out_rts 0, inp_rtr 1, out_data 0, almost_empty 1, almost_full 0. Handshakes ignored while rst_n low; reset mid-transfer discards all entries.
- Write-to-read latency: entry written at edge N is on out_data with out_rts = 1 after edge N (visible cycle N+1).
- Read: head changes to next entry immediately after the consuming edge; zero-cycle read latency.
- Full with simultaneous rd/wr attempt: read taken, write refused (inp_rtr = 0), overflow set; count DEPTH-1 next cycle.
- Empty with simultaneous rd/wr attempt: write taken, read refused, underflow set; count 1 next cycle.
- Flags and counter update on the same edge as the pointer change.

## Structure
- Package i2si_fifo_pkg: default DATA_W/ADDR_W constants and a function computing DEPTH from ADDR_W; shared with the future output-side FIFO.
- Sub-module i2si_fifo_mem: DEPTH x DATA_W register array, synchronous write port, asynchronous read port. Control (pointers, count, flags) stays in the top module.

## Test plan
- Reset then idle: rst_n low with inp_rts = 1 -> count 0, out_rts 0, inp_rtr 1, out_data 0; no entry written.
- Defaults, write 0x11..0x18 back-to-back -> count 8, inp_rtr 0, almost_full from count 6; read 8 -> 0x11..0x18 in order, out_data 0x11 visible cycle after first write.
- Full, assert inp_rts with 0xAA and out_rtr together -> 0x11 read, 0xAA dropped, overflow 1, count 7; stays 1 until flush.
- Wrap: 20 writes/reads interleaved at steady count 3 -> data order preserved across pointer wrap, count constant 3.
- Empty, out_rtr = 1 and inp_rts with 0x55 -> underflow 1, count 1, out_data 0x55 next cycle.
- Count 5 with flags set, flush with concurrent write 0x77 -> count 0, flags 0, 0x77 not stored; DATA_W = 16, ADDR_W = 4 rerun of write/read order.

Source files
------------

// File: rtl/i2si_fifo_pkg.sv
// Shared constants and helpers for the I2S input/output sample FIFOs.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   I2SI_DATA_W  default data bits per FIFO entry
//   I2SI_ADDR_W  default pointer width (DEPTH = 2**ADDR_W)
//   fifo_depth() entry count implied by a pointer width
package i2si_fifo_pkg;

  localparam int I2SI_DATA_W = 8;
  localparam int I2SI_ADDR_W = 3;

  // Number of entries addressed by an addr_w-bit pointer.
  function automatic int fifo_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/i2si_fifo_mem.sv
// Storage array for the I2S sample FIFO: DEPTH x DATA_W registers.
// Latency: write lands at the clock edge; read is combinational from rd_addr.
// Backpressure: none here; the owning FIFO only asserts wr_en when it has room.
//
// Ports:
//   clk      system clock, write on rising edge
//   wr_en    store wr_data at wr_addr this edge
//   wr_addr  write location
//   wr_data  write data
//   rd_addr  read location
//   rd_data  contents at rd_addr (asynchronous read)
module i2si_fifo_mem
  import i2si_fifo_pkg::*;
#(
  parameter int DATA_W = I2SI_DATA_W,
  parameter int ADDR_W = I2SI_ADDR_W
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = fifo_depth(ADDR_W);

  // Deliberately not reset: the owning FIFO never exposes an entry it has
  // not written since the last reset or flush.
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/i2si_param_fifo.sv
// Parametrised first-word-fall-through FIFO between I2S deserialiser and sample consumer.
// Latency: write at edge N is on out_data after edge N; a read advances the head at the consuming edge.
// Backpressure: inp_rtr drops when full, out_rts drops when empty; both decoded from the registered count only.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 synchronous clear of contents and error flags
//   i2si_fifo_inp_*       write side: data / rts (writer has data) / rtr (room available)
//   i2si_fifo_out_*       read side: data (head, zero when empty) / rts (not empty) / rtr (consume head)
//   fifo_counter          entries held, 0..DEPTH
//   almost_full/empty     count >= AFULL_LVL / count <= AEMPTY_LVL
//   overflow/underflow    sticky: write while full / read while empty
module i2si_param_fifo
  import i2si_fifo_pkg::*;
#(
  parameter int DATA_W     = I2SI_DATA_W,
  parameter int ADDR_W     = I2SI_ADDR_W,
  parameter int AFULL_LVL  = fifo_depth(ADDR_W) - 2,
  parameter int AEMPTY_LVL = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [DATA_W-1:0] i2si_fifo_inp_data,
  input  logic              i2si_fifo_inp_rts,
  output logic              i2si_fifo_inp_rtr,
  output logic [DATA_W-1:0] i2si_fifo_out_data,
  output logic              i2si_fifo_out_rts,
  input  logic              i2si_fifo_out_rtr,
  output logic [ADDR_W:0]   fifo_counter,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow
);

  localparam int DEPTH = fifo_depth(ADDR_W);

  // Thresholds and depth at counter width so comparisons are width-matched.
  localparam logic [ADDR_W:0] DEPTH_C  = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] AFULL_C  = AFULL_LVL[ADDR_W:0];
  localparam logic [ADDR_W:0] AEMPTY_C = AEMPTY_LVL[ADDR_W:0];

  // Illegal parameter combinations stop elaboration.
  if (ADDR_W < 1) begin : g_bad_addr_w
    $error("i2si_param_fifo: ADDR_W must be at least 1");
  end
  if (AEMPTY_LVL >= AFULL_LVL) begin : g_bad_aempty
    $error("i2si_param_fifo: AEMPTY_LVL must be below AFULL_LVL");
  end
  if (AFULL_LVL > DEPTH) begin : g_bad_afull
    $error("i2si_param_fifo: AFULL_LVL must not exceed DEPTH");
  end

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic              ovf;
  logic              udf;
  logic              not_full;
  logic              not_empty;
  logic              wr_fire;
  logic              rd_fire;
  logic [DATA_W-1:0] head_data;

  // Ready signals come from the registered count alone: a full FIFO does not
  // accept a write even when a read is leaving in the same cycle, and an
  // empty FIFO never bypasses the incoming word to the output.
  assign not_full  = (count != DEPTH_C);
  assign not_empty = (count != '0);

  // Flush wins over any handshake in the same cycle.
  assign wr_fire = i2si_fifo_inp_rts & not_full  & ~flush;
  assign rd_fire = i2si_fifo_out_rtr & not_empty & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else begin
      if (wr_fire) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_fire) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({wr_fire, rd_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // Error flags are sticky until flush or reset.
      if (i2si_fifo_inp_rts && !not_full) begin
        ovf <= 1'b1;
      end
      if (i2si_fifo_out_rtr && !not_empty) begin
        udf <= 1'b1;
      end
    end
  end

  i2si_fifo_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_fire),
    .wr_addr (wr_ptr),
    .wr_data (i2si_fifo_inp_data),
    .rd_addr (rd_ptr),
    .rd_data (head_data)
  );

  // Head is forced to zero when empty so stale array contents never leak out.
  assign i2si_fifo_out_data = not_empty ? head_data : '0;
  assign i2si_fifo_out_rts  = not_empty;
  assign i2si_fifo_inp_rtr  = not_full;
  assign fifo_counter       = count;
  assign almost_full        = (count >= AFULL_C);
  assign almost_empty       = (count <= AEMPTY_C);
  assign overflow           = ovf;
  assign underflow          = udf;

  // Occupancy can never exceed the array size.
  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
    count <= DEPTH_C);

  // Ready outputs are mutually consistent with the count.
  a_ready_decode: assert property (@(posedge clk) disable iff (!rst_n)
    (not_full || not_empty));

endmodule

// File: tb/tb_i2si_param_fifo.sv
module tb_i2si_param_fifo;

  logic clk;
  logic rst_n;

  // Instance A: default parameters (8 bit x 8 entries, AFULL 6, AEMPTY 1).
  logic        a_flush;
  logic [7:0]  a_inp_data;
  logic        a_inp_rts;
  logic        a_inp_rtr;
  logic [7:0]  a_out_data;
  logic        a_out_rts;
  logic        a_out_rtr;
  logic [3:0]  a_count;
  logic        a_afull;
  logic        a_aempty;
  logic        a_ovf;
  logic        a_udf;

  // Instance B: 16 bit x 16 entries (AFULL 14, AEMPTY 1).
  logic        b_flush;
  logic [15:0] b_inp_data;
  logic        b_inp_rts;
  logic        b_inp_rtr;
  logic [15:0] b_out_data;
  logic        b_out_rts;
  logic        b_out_rtr;
  logic [4:0]  b_count;
  logic        b_afull;
  logic        b_aempty;
  logic        b_ovf;
  logic        b_udf;

  int n_chk;
  int n_fail;

  i2si_param_fifo u_dut_a (
    .clk                (clk),
    .rst_n              (rst_n),
    .flush              (a_flush),
    .i2si_fifo_inp_data (a_inp_data),
    .i2si_fifo_inp_rts  (a_inp_rts),
    .i2si_fifo_inp_rtr  (a_inp_rtr),
    .i2si_fifo_out_data (a_out_data),
    .i2si_fifo_out_rts  (a_out_rts),
    .i2si_fifo_out_rtr  (a_out_rtr),
    .fifo_counter       (a_count),
    .almost_full        (a_afull),
    .almost_empty       (a_aempty),
    .overflow           (a_ovf),
    .underflow          (a_udf)
  );

  i2si_param_fifo #(
    .DATA_W (16),
    .ADDR_W (4)
  ) u_dut_b (
    .clk                (clk),
    .rst_n              (rst_n),
    .flush              (b_flush),
    .i2si_fifo_inp_data (b_inp_data),
    .i2si_fifo_inp_rts  (b_inp_rts),
    .i2si_fifo_inp_rtr  (b_inp_rtr),
    .i2si_fifo_out_data (b_out_data),
    .i2si_fifo_out_rts  (b_out_rts),
    .i2si_fifo_out_rtr  (b_out_rtr),
    .fifo_counter       (b_count),
    .almost_full        (b_afull),
    .almost_empty       (b_aempty),
    .overflow           (b_ovf),
    .underflow          (b_udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    a_flush = 1'b0; a_inp_data = 8'h99; a_inp_rts = 1'b1; a_out_rtr = 1'b0;
    b_flush = 1'b0; b_inp_data = '0;    b_inp_rts = 1'b0; b_out_rtr = 1'b0;

    // Reset with the writer pushing: nothing may be stored.
    tick(); tick();
    check("rst_count",  32'(a_count),    32'd0);
    check("rst_out_rts", 32'(a_out_rts), 32'd0);
    check("rst_inp_rtr", 32'(a_inp_rtr), 32'd1);
    check("rst_out_data", 32'(a_out_data), 32'h0);
    check("rst_aempty", 32'(a_aempty),   32'd1);
    check("rst_afull",  32'(a_afull),    32'd0);
    check("rst_ovf",    32'(a_ovf),      32'd0);
    a_inp_rts = 1'b0;
    rst_n = 1'b1;
    tick();
    check("post_rst_count", 32'(a_count), 32'd0);

    // Fill with 0x11..0x18.
    for (int i = 0; i < 8; i++) begin
      a_inp_data = 8'(8'h11 + i);
      a_inp_rts  = 1'b1;
      tick();
      check("fill_count", 32'(a_count), 32'(i + 1));
      check("fill_afull", 32'(a_afull), 32'((i + 1) >= 6));
      check("fill_aempty", 32'(a_aempty), 32'((i + 1) <= 1));
      if (i == 0) begin
        check("fwft_head", 32'(a_out_data), 32'h11);
        check("fwft_rts",  32'(a_out_rts),  32'd1);
      end
    end
    a_inp_rts = 1'b0;
    check("full_rtr", 32'(a_inp_rtr), 32'd0);
    check("full_ovf", 32'(a_ovf),     32'd0);

    // Full with simultaneous read and write: read taken, write dropped.
    a_inp_data = 8'hAA;
    a_inp_rts  = 1'b1;
    a_out_rtr  = 1'b1;
    check("full_rw_head", 32'(a_out_data), 32'h11);
    tick();
    a_inp_rts = 1'b0;
    check("full_rw_count", 32'(a_count),    32'd7);
    check("full_rw_ovf",   32'(a_ovf),      32'd1);
    check("full_rw_next",  32'(a_out_data), 32'h12);

    // Drain the rest; 0xAA must never appear.
    for (int i = 0; i < 7; i++) begin
      check("drain_data", 32'(a_out_data), 32'(8'h12 + i));
      tick();
    end
    a_out_rtr = 1'b0;
    check("drain_count",  32'(a_count),    32'd0);
    check("drain_rts",    32'(a_out_rts),  32'd0);
    check("drain_zero",   32'(a_out_data), 32'h0);
    check("ovf_sticky",   32'(a_ovf),      32'd1);
    check("drain_udf",    32'(a_udf),      32'd0);
    tick();
    check("ovf_sticky2",  32'(a_ovf),      32'd1);

    a_flush = 1'b1;
    tick();
    a_flush = 1'b0;
    check("flush_ovf", 32'(a_ovf), 32'd0);

    // Steady state at count 3 across pointer wrap.
    for (int i = 0; i < 3; i++) begin
      a_inp_data = 8'(8'h30 + i);
      a_inp_rts  = 1'b1;
      tick();
    end
    check("wrap_pre_count", 32'(a_count), 32'd3);
    a_out_rtr = 1'b1;
    for (int k = 0; k < 20; k++) begin
      a_inp_data = 8'(8'h33 + k);
      check("wrap_data", 32'(a_out_data), 32'(8'h30 + k));
      tick();
      check("wrap_count", 32'(a_count), 32'd3);
    end
    a_inp_rts = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("wrap_tail", 32'(a_out_data), 32'(8'h44 + k));
      tick();
    end
    a_out_rtr = 1'b0;
    check("wrap_empty", 32'(a_count), 32'd0);

    // Empty with simultaneous read and write: write taken, read refused.
    a_inp_data = 8'h55;
    a_inp_rts  = 1'b1;
    a_out_rtr  = 1'b1;
    tick();
    a_inp_rts = 1'b0;
    a_out_rtr = 1'b0;
    check("empty_rw_udf",   32'(a_udf),      32'd1);
    check("empty_rw_count", 32'(a_count),    32'd1);
    check("empty_rw_data",  32'(a_out_data), 32'h55);

    // Bring count to 5, then flush against a concurrent write and read.
    for (int i = 0; i < 4; i++) begin
      a_inp_data = 8'(8'h60 + i);
      a_inp_rts  = 1'b1;
      tick();
    end
    a_inp_rts = 1'b0;
    check("pre_flush_count", 32'(a_count), 32'd5);
    check("pre_flush_udf",   32'(a_udf),   32'd1);
    a_flush    = 1'b1;
    a_inp_data = 8'h77;
    a_inp_rts  = 1'b1;
    a_out_rtr  = 1'b1;
    tick();
    a_flush   = 1'b0;
    a_inp_rts = 1'b0;
    a_out_rtr = 1'b0;
    check("flush_count", 32'(a_count), 32'd0);
    check("flush_udf",   32'(a_udf),   32'd0);
    check("flush_ovf2",  32'(a_ovf),   32'd0);
    tick();
    check("flush_no_store", 32'(a_count),    32'd0);
    check("flush_data",     32'(a_out_data), 32'h0);

    // Wider, deeper instance: fill 16, check full flags, read back in order.
    for (int i = 0; i < 16; i++) begin
      b_inp_data = 16'(16'h1000 + i * 16'h0111);
      b_inp_rts  = 1'b1;
      tick();
      if (i == 13) check("b_afull_at14", 32'(b_afull), 32'd1);
      if (i == 12) check("b_afull_at13", 32'(b_afull), 32'd0);
    end
    b_inp_rts = 1'b0;
    check("b_full_count", 32'(b_count),   32'd16);
    check("b_full_rtr",   32'(b_inp_rtr), 32'd0);
    b_out_rtr = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("b_read_data", 32'(b_out_data), 32'(16'h1000 + i * 16'h0111));
      tick();
    end
    b_out_rtr = 1'b0;
    check("b_empty_count", 32'(b_count),  32'd0);
    check("b_aempty",      32'(b_aempty), 32'd1);
    check("b_udf",         32'(b_udf),    32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
